// File: rtl/vga_draw_pkg.sv
// Shared constants, FSM state type and sprite mask for the VGA circle drawer.
package vga_draw_pkg;

    localparam int unsigned SCREEN_W   = 160;
    localparam int unsigned SCREEN_H   = 120;
    localparam int unsigned SPRITE_DIM = 7;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned CELL_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // 7x7 circle: rows 0/6 keep cols 2..4, rows 1/5 keep cols 1..5, rows 2..4 keep all.
    function automatic logic in_mask(input logic [CELL_W-1:0] row,
                                     input logic [CELL_W-1:0] col);
        logic [CELL_W-1:0] m;
        unique case (row)
            3'd0, 3'd6: m = 3'd2;
            3'd1, 3'd5: m = 3'd1;
            default:    m = 3'd0;
        endcase
        return (col >= m) && (col <= (3'd6 - m));
    endfunction

endpackage

// File: rtl/circle_draw_arbiter_if.sv
// Requester handshake plus pixel-adapter outputs of the circle draw arbiter.
interface circle_draw_arbiter_if
    import vga_draw_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*X_W-1:0]      req_x;
    logic [NUM_REQ*Y_W-1:0]      req_y;
    logic [NUM_REQ*COLOUR_W-1:0] req_colour;

    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          done;
    logic [X_W-1:0]              x;
    logic [Y_W-1:0]              y;
    logic [COLOUR_W-1:0]         colour;
    logic                        plot;
    logic                        busy;

    modport master (
        output req, req_x, req_y, req_colour,
        input  grant, done, x, y, colour, plot, busy
    );

    modport slave (
        input  req, req_x, req_y, req_colour,
        output grant, done, x, y, colour, plot, busy
    );

endinterface

// File: rtl/circle_draw_arbiter_rr_arbiter.sv
// Combinational round-robin select: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    int unsigned slot;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        slot  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            slot = 32'(ptr_i) + k;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (!found && req_i[PTR_W'(slot)]) begin
                found                = 1'b1;
                gnt_o[PTR_W'(slot)]  = 1'b1;
                idx_o                = PTR_W'(slot);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/circle_draw_arbiter.sv
// Round-robin owner of the VGA pixel port; each grant emits one clipped 7x7 circle,
// one cell per clock, then pulses done to the owning requester.
module circle_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned SPRITE_DIM = 7
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    circle_draw_arbiter_if.slave bus
);

    localparam int unsigned     PTR_W = $clog2(NUM_REQ);
    localparam logic [CELL_W-1:0] LAST  = CELL_W'(SPRITE_DIM - 1);
    localparam logic [X_W:0]    X_MAX = (X_W+1)'(SCREEN_W - 1);
    localparam logic [Y_W:0]    Y_MAX = (Y_W+1)'(SCREEN_H - 1);

    state_e                state_q, state_d;
    logic [CELL_W-1:0]     row_q, row_d;
    logic [CELL_W-1:0]     col_q, col_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [X_W-1:0]        base_x_q, base_x_d;
    logic [Y_W-1:0]        base_y_q, base_y_d;
    logic [COLOUR_W-1:0]   base_colour_q, base_colour_d;
    logic [NUM_REQ-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic                  plot_q, plot_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_valid;

    logic [X_W-1:0]        req_x_a      [NUM_REQ];
    logic [Y_W-1:0]        req_y_a      [NUM_REQ];
    logic [COLOUR_W-1:0]   req_colour_a [NUM_REQ];

    // One extra bit so that off-screen sums are detected instead of wrapping.
    logic [X_W:0]          x_sum;
    logic [Y_W:0]          y_sum;

    for (genvar gi = 0; gi < int'(NUM_REQ); gi++) begin : g_unpack
        assign req_x_a[gi]      = bus.req_x[gi*X_W +: X_W];
        assign req_y_a[gi]      = bus.req_y[gi*Y_W +: Y_W];
        assign req_colour_a[gi] = bus.req_colour[gi*COLOUR_W +: COLOUR_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign x_sum = (X_W+1)'(base_x_q) + (X_W+1)'(col_q);
    assign y_sum = (Y_W+1)'(base_y_q) + (Y_W+1)'(row_q);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            rr_ptr_q      <= '0;
            base_x_q      <= '0;
            base_y_q      <= '0;
            base_colour_q <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            colour_q      <= '0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            rr_ptr_q      <= rr_ptr_d;
            base_x_q      <= base_x_d;
            base_y_q      <= base_y_d;
            base_colour_q <= base_colour_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            x_q           <= x_d;
            y_q           <= y_d;
            colour_q      <= colour_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        rr_ptr_d      = rr_ptr_q;
        base_x_d      = base_x_q;
        base_y_d      = base_y_q;
        base_colour_d = base_colour_q;
        owner_d       = owner_q;
        grant_d       = '0;
        done_d        = '0;
        x_d           = x_q;
        y_d           = y_q;
        colour_d      = colour_q;
        plot_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    base_x_d      = req_x_a[arb_idx];
                    base_y_d      = req_y_a[arb_idx];
                    base_colour_d = req_colour_a[arb_idx];
                    owner_d       = arb_gnt;
                    grant_d       = arb_gnt;
                    rr_ptr_d      = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                     : arb_idx + PTR_W'(1);
                    state_d       = S_GRANT;
                end
            end

            // Cell (0,0) is emitted on the GRANT edge; the rest follow in row-major order.
            S_GRANT, S_DRAW: begin
                x_d      = x_sum[X_W-1:0];
                y_d      = y_sum[Y_W-1:0];
                colour_d = base_colour_q;
                plot_d   = in_mask(row_q, col_q) && (x_sum <= X_MAX) && (y_sum <= Y_MAX);
                state_d  = S_DRAW;
                if (col_q == LAST) begin
                    col_d = '0;
                    if (row_q == LAST) begin
                        row_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + CELL_W'(1);
                    end
                end else begin
                    col_d = col_q + CELL_W'(1);
                end
            end

            S_DONE: begin
                done_d  = owner_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Busy covers the grant cycle through the done-pulse cycle.
    assign busy_d = (state_d != S_IDLE) || (done_d != '0);

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_circle_draw_arbiter.sv
// Bench for circle_draw_arbiter: directed handshake scenarios plus random requesters,
// all checked cycle by cycle against a sprite-timeline reference model.
module tb_circle_draw_arbiter;

    localparam int NR         = 4;
    localparam int SPRITE_CYC = 51;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    logic chk_on   = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    circle_draw_arbiter_if #(.NUM_REQ(NR)) bus ();

    circle_draw_arbiter #(
        .NUM_REQ    (NR),
        .SPRITE_DIM (7)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [NR-1:0] v, input int i);
        return ((v >> i) & NR'(1)) != '0;
    endfunction

    function automatic int onehot_to_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (bit_at(v, i)) return i;
        end
        return -1;
    endfunction

    // Circle by geometry: centre-relative squared distance in half-cell units.
    function automatic bit in_circle(input int row, input int col);
        int dx;
        int dy;
        dx = 2 * col - 6;
        dy = 2 * row - 6;
        return (dx * dx + dy * dy) <= 40;
    endfunction

    // Reference model: m_t counts cycles since the capture edge (0 = free).
    int              m_t   = 0;
    int              m_ptr = 0;
    int              m_sel = 0;
    int              mk, mr, mc, mxs, mys;
    logic [7:0]      m_bx  = '0;
    logic [6:0]      m_by  = '0;
    logic [2:0]      m_bc  = '0;
    logic [NR-1:0]   e_grant = '0;
    logic [NR-1:0]   e_done  = '0;
    logic            e_plot  = 1'b0;
    logic            e_busy  = 1'b0;
    logic [7:0]      e_x     = '0;
    logic [6:0]      e_y     = '0;
    logic [2:0]      e_c     = '0;

    always @(posedge CLOCK_50 or posedge reset) begin
        e_plot = 1'b0;
        if (reset) begin
            m_t   = 0;
            m_ptr = 0;
            e_x   = '0;
            e_y   = '0;
            e_c   = '0;
        end else begin
            if (m_t == 0 || m_t == SPRITE_CYC) begin
                m_t = 0;
                for (int k = 0; k < NR; k++) begin
                    mk = (m_ptr + k) % NR;
                    if (m_t == 0 && bit_at(bus.req, mk)) begin
                        m_sel = mk;
                        m_t   = 1;
                    end
                end
                if (m_t == 1) begin
                    m_bx  = 8'(bus.req_x >> (8 * m_sel));
                    m_by  = 7'(bus.req_y >> (7 * m_sel));
                    m_bc  = 3'(bus.req_colour >> (3 * m_sel));
                    m_ptr = (m_sel + 1) % NR;
                end
            end else begin
                m_t++;
            end
            if (m_t >= 2 && m_t <= 50) begin
                mk     = m_t - 2;
                mr     = mk / 7;
                mc     = mk % 7;
                mxs    = int'(m_bx) + mc;
                mys    = int'(m_by) + mr;
                e_x    = 8'(mxs);
                e_y    = 7'(mys);
                e_c    = m_bc;
                e_plot = in_circle(mr, mc) && (mxs < 160) && (mys < 120);
            end
        end
        e_grant = (m_t == 1)          ? (NR'(1) << m_sel) : '0;
        e_done  = (m_t == SPRITE_CYC) ? (NR'(1) << m_sel) : '0;
        e_busy  = (m_t != 0);
    end

    always @(negedge CLOCK_50) begin
        if (chk_on) begin
            check_eq("grant",  64'(bus.grant),  64'(e_grant));
            check_eq("done",   64'(bus.done),   64'(e_done));
            check_eq("plot",   64'(bus.plot),   64'(e_plot));
            check_eq("busy",   64'(bus.busy),   64'(e_busy));
            check_eq("x",      64'(bus.x),      64'(e_x));
            check_eq("y",      64'(bus.y),      64'(e_y));
            check_eq("colour", 64'(bus.colour), 64'(e_c));
        end
    end

    // Observation log used by the directed scenarios.
    int cyc = 0;
    int plot_cnt, busy_cnt, oob_cnt, min_x, min_y;
    int first_x, first_y, last_x, last_y;
    int g_idx[$];
    int g_cyc[$];
    int d_idx[$];
    int d_cyc[$];

    always @(negedge CLOCK_50) begin
        cyc++;
        if (bus.plot === 1'b1) begin
            if (plot_cnt == 0) begin
                first_x = int'(bus.x);
                first_y = int'(bus.y);
            end
            last_x = int'(bus.x);
            last_y = int'(bus.y);
            if (int'(bus.x) > 159 || int'(bus.y) > 119) oob_cnt++;
            if (int'(bus.x) < min_x) min_x = int'(bus.x);
            if (int'(bus.y) < min_y) min_y = int'(bus.y);
            plot_cnt++;
        end
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.grant != '0) begin
            g_idx.push_back(onehot_to_idx(bus.grant));
            g_cyc.push_back(cyc);
        end
        if (bus.done != '0) begin
            d_idx.push_back(onehot_to_idx(bus.done));
            d_cyc.push_back(cyc);
        end
    end

    task automatic clear_stats();
        plot_cnt = 0;
        busy_cnt = 0;
        oob_cnt  = 0;
        min_x    = 1000;
        min_y    = 1000;
        first_x  = -1;
        first_y  = -1;
        last_x   = -1;
        last_y   = -1;
        g_idx.delete();
        g_cyc.delete();
        d_idx.delete();
        d_cyc.delete();
    endtask

    task automatic step();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic set_ops(input int i, input int xv, input int yv, input int cv);
        bus.req_x[8*i +: 8]      = 8'(xv);
        bus.req_y[7*i +: 7]      = 7'(yv);
        bus.req_colour[3*i +: 3] = 3'(cv);
    endtask

    task automatic set_req(input int i, input bit v);
        if (v) bus.req = bus.req | (NR'(1) << i);
        else   bus.req = bus.req & ~(NR'(1) << i);
    endtask

    task automatic apply_reset();
        bus.req = '0;
        reset   = 1'b1;
        step();
        check_eq("rst_outputs",
                 64'({bus.grant, bus.done, bus.plot, bus.busy, bus.x, bus.y, bus.colour}), 64'(0));
        step();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int n = 0; n < 300; n++) begin
            step();
            if (bus.grant != '0) begin
                idx = onehot_to_idx(bus.grant);
                break;
            end
        end
        check_eq("grant_seen", 64'(idx >= 0), 64'(1));
    endtask

    task automatic wait_done(output int idx);
        idx = -1;
        for (int n = 0; n < 300; n++) begin
            step();
            if (bus.done != '0) begin
                idx = onehot_to_idx(bus.done);
                break;
            end
        end
        check_eq("done_seen", 64'(idx >= 0), 64'(1));
    endtask

    int gi, di, t0, lane1_hits;

    initial begin
        bus.req        = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        clear_stats();
        apply_reset();
        chk_on = 1'b1;

        // Single sprite fully on screen
        clear_stats();
        set_ops(0, 10, 20, 3'b100);
        set_req(0, 1'b1);
        wait_grant(gi);
        set_req(0, 1'b0);
        check_eq("t1_grant_idx", 64'(gi), 64'(0));
        wait_done(di);
        check_eq("t1_done_idx", 64'(di), 64'(0));
        repeat (3) step();
        check_eq("t1_plots",   64'(plot_cnt), 64'(37));
        check_eq("t1_first_x", 64'(first_x),  64'(12));
        check_eq("t1_first_y", 64'(first_y),  64'(20));
        check_eq("t1_last_x",  64'(last_x),   64'(14));
        check_eq("t1_last_y",  64'(last_y),   64'(26));
        check_eq("t1_busy",    64'(busy_cnt), 64'(51));
        if (g_cyc.size() == 1 && d_cyc.size() == 1)
            check_eq("t1_done_lat", 64'(d_cyc[0] - g_cyc[0]), 64'(50));
        else
            check_eq("t1_log_len", 64'(g_cyc.size() + d_cyc.size()), 64'(2));

        // Round-robin with every requester held high
        apply_reset();
        clear_stats();
        for (int i = 0; i < NR; i++) set_ops(i, 20 * i, 10 + 5 * i, i + 1);
        bus.req = '1;
        for (int n = 0; n < 400; n++) begin
            step();
            if (g_idx.size() >= 5) break;
        end
        bus.req = '0;
        repeat (60) step();
        check_eq("rr_count", 64'(g_idx.size() >= 5), 64'(1));
        if (g_idx.size() >= 5) begin
            for (int k = 0; k < 5; k++) check_eq("rr_order", 64'(g_idx[k]), 64'(k % NR));
            for (int k = 0; k < 4; k++) check_eq("rr_gap", 64'(g_cyc[k+1] - g_cyc[k]), 64'(51));
        end

        // Clipping at the bottom-right corner
        apply_reset();
        clear_stats();
        set_ops(1, 156, 116, 3'b010);
        set_req(1, 1'b1);
        wait_grant(gi);
        set_req(1, 1'b0);
        wait_done(di);
        repeat (2) step();
        check_eq("clip_plots", 64'(plot_cnt), 64'(13));
        check_eq("clip_oob",   64'(oob_cnt),  64'(0));
        check_eq("clip_min_x", 64'(min_x),    64'(156));
        check_eq("clip_min_y", 64'(min_y),    64'(116));

        // Reset in the middle of a sprite
        apply_reset();
        set_ops(0, 40, 30, 3'b001);
        set_ops(2, 70, 50, 3'b110);
        set_req(0, 1'b1);
        wait_grant(gi);
        set_req(0, 1'b0);
        set_req(2, 1'b1);
        repeat (20) step();
        clear_stats();
        #1 reset = 1'b1;
        #1 check_eq("rst_async",
                    64'({bus.grant, bus.done, bus.plot, bus.busy, bus.x, bus.y, bus.colour}), 64'(0));
        step();
        reset = 1'b0;
        wait_grant(gi);
        check_eq("rst_regrant_idx", 64'(gi), 64'(2));
        check_eq("rst_no_done",     64'(d_idx.size()), 64'(0));
        set_req(2, 1'b0);
        wait_done(di);
        check_eq("rst_done_idx", 64'(di), 64'(2));

        // Request withdrawn before it could be granted
        apply_reset();
        clear_stats();
        set_ops(0, 50, 60, 3'b111);
        set_req(0, 1'b1);
        wait_grant(gi);
        set_req(0, 1'b0);
        repeat (10) step();
        set_ops(1, 5, 5, 3'b011);
        set_req(1, 1'b1);
        step();
        set_req(1, 1'b0);
        wait_done(di);
        repeat (60) step();
        lane1_hits = 0;
        foreach (g_idx[k]) if (g_idx[k] == 1) lane1_hits++;
        foreach (d_idx[k]) if (d_idx[k] == 1) lane1_hits++;
        check_eq("wd_lane1_hits", 64'(lane1_hits), 64'(0));
        check_eq("wd_grants",     64'(g_idx.size()), 64'(1));
        check_eq("wd_dones",      64'(d_idx.size()), 64'(1));

        // Back-to-back: pointer wraps from 3 to 0
        apply_reset();
        set_ops(3, 100, 80, 3'b101);
        set_ops(0, 30, 40, 3'b011);
        set_req(3, 1'b1);
        wait_grant(gi);
        check_eq("b2b_first_idx", 64'(gi), 64'(3));
        set_req(3, 1'b0);
        wait_done(di);
        check_eq("b2b_done_idx", 64'(di), 64'(3));
        set_req(0, 1'b1);
        set_req(3, 1'b1);
        t0 = cyc;
        wait_grant(gi);
        check_eq("b2b_second_idx", 64'(gi), 64'(0));
        check_eq("b2b_gap",        64'(cyc - t0), 64'(1));
        set_req(0, 1'b0);
        wait_grant(gi);
        check_eq("b2b_third_idx", 64'(gi), 64'(3));
        set_req(3, 1'b0);
        wait_done(di);

        // Random requesters obeying the handshake
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (bit_at(bus.grant, i)) begin
                    if ($urandom_range(0, 3) == 0)
                        set_ops(i, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
                    else
                        set_req(i, 1'b0);
                end else if (bit_at(bus.req, i)) begin
                    if ($urandom_range(0, 63) == 0) set_req(i, 1'b0);
                end else if ($urandom_range(0, 15) == 0) begin
                    set_ops(i, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
                    set_req(i, 1'b1);
                end
            end
        end
        bus.req = '0;
        repeat (60) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/circle_draw_arbiter.md
Name: circle_draw_arbiter

Overview:
Shares the single pixel-write port of the 160x120 VGA adapter among NUM_REQ sprite requesters, such as note lanes and drum-hit markers.
Each granted request is drawn as a 7x7 circle: the block walks all 49 cells and asserts plot only on the 37 mask cells that lie on screen.
Requesters are served round-robin with a req/grant/done handshake. The block drives the adapter's x, y, colour and plot inputs directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SPRITE_DIM, 7, sprite edge length; the circle mask is defined only for 7

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester draw request, level-held until grant
req_x  in  NUM_REQ*8  top-left x per requester; slice i is [8i+7:8i]
req_y  in  NUM_REQ*7  top-left y per requester
req_colour  in  NUM_REQ*3  RGB colour per requester
grant  out  NUM_REQ  one-hot, one-cycle pulse; the request is captured this cycle
done  out  NUM_REQ  one-hot, one-cycle pulse; the sprite is fully emitted
x  out  8  pixel x to the adapter
y  out  7  pixel y to the adapter
colour  out  3  pixel colour to the adapter
plot  out  1  write enable to the adapter
busy  out  1  high in the GRANT, DRAW and DONE states

Behaviour:
- Reset (asynchronous, active-high):
  - state IDLE; row, col and rr_ptr all 0.
  - Outputs x, y, colour, plot, grant, done and busy all 0.
  - A reset during DRAW aborts the job with no done pulse; the requester must re-request.
- States: IDLE -> GRANT -> DRAW -> DONE -> IDLE.
- IDLE:
  - When no req bit is set, hold the state with plot=0.
  - Otherwise, at edge E0 select the first set bit scanning from rr_ptr upward, modulo NUM_REQ.
  - Capture that requester's x, y and colour into base registers.
  - Set grant[i]=1 and rr_ptr=(i+1) mod NUM_REQ, then move to GRANT.
- GRANT:
  - grant[i] is high for exactly this cycle.
  - At edge E1, emit cell (row 0, col 0), clear grant, and move to DRAW.
- DRAW:
  - Edges E1..E49 each register one cell. Visiting order is row-major: col increments and wraps to 0 after 6, and row then increments.
  - x = base_x + col, computed in 9 bits.
  - y = base_y + row, computed in 8 bits.
  - colour = base_colour.
  - plot = in_mask(row,col) AND x_sum<=159 AND y_sum<=119. Off-screen cells are suppressed, never wrapped.
  - The mask excludes cells with col<m or col>6-m, where m = 2 for rows 0 and 6, 1 for rows 1 and 5, and 0 for rows 2-4.
  - x and y are updated on every cell even when plot=0.
  - After cell (6,6) is registered at E49, move to DONE.
- DONE:
  - At edge E50, set plot=0 and pulse done[i] for one cycle, then return to IDLE.
  - The earliest next capture is at E51, giving 51 cycles per sprite.
- Handshake rules:
  - The requester holds req and its operands stable until it sees grant. Operands are don't-care after grant.
  - Deasserting req before grant withdraws the request; no grant or done is issued.
  - req still high in the cycle after grant is treated as a new request and is served no earlier than the next round-robin turn.
- Simultaneous events: requests that arrive during GRANT, DRAW or DONE are only sampled at the next IDLE edge.

Decomposition:
- Shared package (vga_draw_pkg):
  - SCREEN_W=160 and SCREEN_H=120.
  - SPRITE_DIM=7.
  - State encoding IDLE, GRANT, DRAW and DONE.
  - The in_mask(row,col) function.
- Sub-module rr_arbiter(NUM_REQ): combinational one-hot select from req and rr_ptr, plus a valid output. The pointer register stays in the parent.

Test Plan:
- Single request, req[0] at x=10, y=20, colour=3'b100:
  - grant[0] pulse, then exactly 37 plot cycles.
  - First plotted pixel (12,20), last plotted pixel (14,26).
  - done[0] one cycle after the last cell; busy high for 51 cycles.
- Round-robin: all 4 req held continuously -> grant order 0, 1, 2, 3, 0, with exactly 51 cycles between grants.
- Clipping, request at x=156, y=116 -> exactly 13 plot cycles, every one with x<=159 and y<=119, and no wrapped coordinates.
- Reset pulse at cycle 20 of DRAW:
  - All outputs 0 asynchronously and no done pulse.
  - After release, a still-held req[2] is granted first, since the pointer is back at 0.
- Withdraw: req[1] raised for 1 cycle while req[0]'s sprite is drawing -> req[1] never receives grant or done.
- Back-to-back requesters: req[3] asserted alone, then req[0] and req[3] both asserted in the IDLE cycle after done[3] -> req[0] is granted, because rr_ptr has wrapped to 0.
